// File: rtl/char_buffer_ctrl.sv
// Command sequencer for the 80x24 circular character buffer write port.
// Optional: CHAR_BUFFER_CLEAR_AT_RESET_EN blanks the whole buffer after reset.
module char_buffer_ctrl #(
    parameter int         ROWS       = 24,
    parameter int         COLS       = 80,
    parameter int         ROW_BITS   = 5,
    parameter int         COL_BITS   = 7,
    parameter int         ADDR_BITS  = 11,
    parameter logic [7:0] BLANK_CHAR = 8'h20
) (
    input  logic                 clk,
    input  logic                 clr_n,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [1:0]           cmd_op,
    input  logic [ROW_BITS-1:0]  cmd_row,
    input  logic [COL_BITS-1:0]  cmd_col,
    input  logic [7:0]           cmd_char,
    output logic [ADDR_BITS-1:0] buffer_waddr,
    output logic [7:0]           buffer_din,
    output logic                 buffer_wen,
    output logic [ADDR_BITS-1:0] buffer_first_char,
    output logic                 buffer_first_char_wen
);

    localparam int SIZE = ROWS * COLS;

    typedef logic [ADDR_BITS:0] wide_t;
    typedef logic [ADDR_BITS-1:0] addr_t;

    localparam wide_t SIZE_W = wide_t'(SIZE);
    localparam wide_t COLS_W = wide_t'(COLS);
    localparam addr_t LAST_A = addr_t'(SIZE - 1);
    localparam logic [ROW_BITS-1:0] ROWS_C = ROW_BITS'(ROWS);
    localparam logic [COL_BITS-1:0] COLS_C = COL_BITS'(COLS);

    localparam logic [1:0] OP_PUT = 2'd0;
    localparam logic [1:0] OP_EOL = 2'd1;
    localparam logic [1:0] OP_EOS = 2'd2;
    localparam logic [1:0] OP_SCR = 2'd3;

    typedef enum logic {IDLE, FILL} state_t;

    state_t     state_q, state_d;
    addr_t      waddr_q, waddr_d;
    addr_t      fc_q, fc_d;
    addr_t      cnt_q, cnt_d;
    logic [7:0] din_q, din_d;
    logic       wen_q, wen_d;
    logic       fcw_q, fcw_d;

    logic  accept, in_range, init_go;
    wide_t lin, sum, fc_sum;
    addr_t phys, fc_nx, waddr_inc;

`ifdef CHAR_BUFFER_CLEAR_AT_RESET_EN
    logic init_q;

    // One-shot flag marking the first cycle after reset release.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) init_q <= 1'b1;
        else        init_q <= 1'b0;
    end

    assign init_go   = init_q;
    assign cmd_ready = (state_q == IDLE) & ~(init_q & clr_n);
`else
    assign init_go   = 1'b0;
    assign cmd_ready = (state_q == IDLE);
`endif

    assign accept    = cmd_valid & cmd_ready;
    assign in_range  = (cmd_row < ROWS_C) & (cmd_col < COLS_C);
    assign lin       = wide_t'(cmd_row) * COLS_W + wide_t'(cmd_col);
    assign sum       = wide_t'(fc_q) + lin;
    assign phys      = (sum >= SIZE_W) ? addr_t'(sum - SIZE_W) : addr_t'(sum);
    assign fc_sum    = wide_t'(fc_q) + COLS_W;
    assign fc_nx     = (fc_sum == SIZE_W) ? '0 : addr_t'(fc_sum);
    assign waddr_inc = (waddr_q == LAST_A) ? '0 : waddr_q + 1'b1;

    // State and registered outputs.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q <= IDLE;
            waddr_q <= '0;
            din_q   <= '0;
            wen_q   <= 1'b0;
            fc_q    <= '0;
            fcw_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            waddr_q <= waddr_d;
            din_q   <= din_d;
            wen_q   <= wen_d;
            fc_q    <= fc_d;
            fcw_q   <= fcw_d;
            cnt_q   <= cnt_d;
        end
    end

    // Command decode and fill sequencing; cnt holds writes left after this one.
    always_comb begin
        state_d = state_q;
        waddr_d = waddr_q;
        din_d   = din_q;
        wen_d   = 1'b0;
        fc_d    = fc_q;
        fcw_d   = 1'b0;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (init_go) begin
                    state_d = FILL;
                    waddr_d = '0;
                    din_d   = BLANK_CHAR;
                    wen_d   = 1'b1;
                    cnt_d   = LAST_A;
                    fc_d    = '0;
                    fcw_d   = 1'b1;
                end else if (accept && (in_range || cmd_op == OP_SCR)) begin
                    wen_d = 1'b1;
                    unique case (cmd_op)
                        OP_PUT: begin
                            waddr_d = phys;
                            din_d   = cmd_char;
                        end
                        OP_EOL: begin
                            state_d = FILL;
                            waddr_d = phys;
                            din_d   = BLANK_CHAR;
                            cnt_d   = addr_t'(COLS_W - wide_t'(cmd_col) - 1'b1);
                        end
                        OP_EOS: begin
                            state_d = FILL;
                            waddr_d = phys;
                            din_d   = BLANK_CHAR;
                            cnt_d   = addr_t'(SIZE_W - lin - 1'b1);
                        end
                        default: begin
                            state_d = FILL;
                            waddr_d = fc_q;
                            din_d   = BLANK_CHAR;
                            cnt_d   = addr_t'(COLS - 1);
                            fc_d    = fc_nx;
                            fcw_d   = 1'b1;
                        end
                    endcase
                end
            end
            FILL: begin
                if (cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    wen_d   = 1'b1;
                    waddr_d = waddr_inc;
                    cnt_d   = cnt_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign buffer_waddr          = waddr_q;
    assign buffer_din            = din_q;
    assign buffer_wen            = wen_q;
    assign buffer_first_char     = fc_q;
    assign buffer_first_char_wen = fcw_q;

endmodule

// File: tb/tb_char_buffer_ctrl.sv
// Scoreboard bench for char_buffer_ctrl.
// Expected writes are queued by stimulus and popped by a negedge monitor.
module tb_char_buffer_ctrl;

    localparam int SIZE = 1920;

    logic        clk = 1'b0;
    logic        clr_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [1:0]  cmd_op = '0;
    logic [4:0]  cmd_row = '0;
    logic [6:0]  cmd_col = '0;
    logic [7:0]  cmd_char = '0;
    logic [10:0] buffer_waddr;
    logic [7:0]  buffer_din;
    logic        buffer_wen;
    logic [10:0] buffer_first_char;
    logic        buffer_first_char_wen;

    char_buffer_ctrl dut (
        .clk                   (clk),
        .clr_n                 (clr_n),
        .cmd_valid             (cmd_valid),
        .cmd_ready             (cmd_ready),
        .cmd_op                (cmd_op),
        .cmd_row               (cmd_row),
        .cmd_col               (cmd_col),
        .cmd_char              (cmd_char),
        .buffer_waddr          (buffer_waddr),
        .buffer_din            (buffer_din),
        .buffer_wen            (buffer_wen),
        .buffer_first_char     (buffer_first_char),
        .buffer_first_char_wen (buffer_first_char_wen)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int fc_m  = 0;
    logic [18:0] wq[$];
    logic [10:0] fq[$];

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: every write strobe and first_char load must match the queue head.
    always @(negedge clk) begin
        if (clr_n) begin
            if (buffer_wen) begin
                if (wq.size() == 0) begin
                    chk("unexpected_write_addr", int'(buffer_waddr), -1);
                end else begin
                    logic [18:0] e;
                    e = wq.pop_front();
                    chk("waddr", int'(buffer_waddr), int'(e[18:8]));
                    chk("din", int'(buffer_din), int'(e[7:0]));
                end
            end
            if (buffer_first_char_wen) begin
                if (fq.size() == 0) begin
                    chk("unexpected_first_char", int'(buffer_first_char), -1);
                end else begin
                    logic [10:0] f;
                    f = fq.pop_front();
                    chk("first_char", int'(buffer_first_char), int'(f));
                end
            end
        end
    end

    function automatic int phys(input int r, input int c);
        int s;
        s = fc_m + r * 80 + c;
        return (s >= SIZE) ? s - SIZE : s;
    endfunction

    task automatic push_w(input int a, input int d);
        wq.push_back({11'(a), 8'(d)});
    endtask

    task automatic push_fill(input int start, input int n);
        for (int i = 0; i < n; i++) push_w((start + i) % SIZE, 8'h20);
    endtask

    task automatic issue(input int op, input int r, input int c, input int ch);
        @(negedge clk);
        chk("ready_before_cmd", int'(cmd_ready), 1);
        cmd_valid = 1'b1;
        cmd_op    = 2'(op);
        cmd_row   = 5'(r);
        cmd_col   = 7'(c);
        cmd_char  = 8'(ch);
        @(posedge clk);
        #1 cmd_valid = 1'b0;
    endtask

    task automatic wait_low(input string name, input int exp_n);
        int cnt;
        cnt = 0;
        @(negedge clk);
        while (!cmd_ready && cnt < 4000) begin
            cnt++;
            @(negedge clk);
        end
        chk(name, cnt, exp_n);
    endtask

    task automatic scroll();
        int nf;
        push_fill(fc_m, 80);
        nf = fc_m + 80;
        if (nf == SIZE) nf = 0;
        fq.push_back(11'(nf));
        issue(3, 0, 0, 0);
        fc_m = nf;
        wait_low("scroll_busy", 80);
    endtask

    task automatic release_reset();
        @(negedge clk);
        clr_n = 1'b1;
`ifdef CHAR_BUFFER_CLEAR_AT_RESET_EN
        push_fill(0, SIZE);
        fq.push_back(11'd0);
        wait_low("init_busy", SIZE);
`else
        wait_low("idle_after_reset", 0);
`endif
    endtask

    initial begin
        #12;
        chk("rst_wen", int'(buffer_wen), 0);
        chk("rst_ready", int'(cmd_ready), 1);
        chk("rst_waddr", int'(buffer_waddr), 0);
        chk("rst_din", int'(buffer_din), 0);
        chk("rst_first_char", int'(buffer_first_char), 0);
        chk("rst_fc_wen", int'(buffer_first_char_wen), 0);
        release_reset();

        push_w(phys(0, 0), 8'h41);
        issue(0, 0, 0, 8'h41);
        wait_low("put_ready", 0);

        push_fill(phys(2, 75), 5);
        issue(1, 2, 75, 0);
        wait_low("eol_busy", 5);

        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = 2'd0;
        cmd_row   = 5'd1;
        cmd_col   = 7'd0;
        cmd_char  = 8'h42;
        push_w(80, 8'h42);
        @(negedge clk);
        chk("b2b_ready", int'(cmd_ready), 1);
        cmd_col  = 7'd1;
        cmd_char = 8'h43;
        push_w(81, 8'h43);
        @(negedge clk);
        chk("b2b_ready2", int'(cmd_ready), 1);
        cmd_valid = 1'b0;

        for (int i = 0; i < 24; i++) scroll();
        chk("fc_after_24", int'(buffer_first_char), 0);

        scroll();
        push_w(79, 8'h5a);
        issue(0, 23, 79, 8'h5a);
        wait_low("put_wrap_ready", 0);

        push_fill(1910, 90);
        issue(2, 22, 70, 0);
        wait_low("eos_wrap_busy", 90);

        push_fill(1900, 20);
        issue(1, 22, 60, 0);
        wait_low("eol_edge_busy", 20);

        for (int i = 0; i < 22; i++) scroll();
        chk("fc_1840", int'(buffer_first_char), 1840);

        push_fill(phys(23, 78), 2);
        issue(2, 23, 78, 0);
        wait_low("eos_n2_busy", 2);

        push_fill(1919, 1);
        issue(1, 0, 79, 0);
        wait_low("eol_n1_busy", 1);

        scroll();
        push_fill(1918, 2);
        issue(2, 23, 78, 0);
        wait_low("eos_fc0_busy", 2);

        issue(0, 24, 0, 8'h55);
        wait_low("oob_row_ready", 0);
        issue(1, 0, 80, 0);
        wait_low("oob_col_ready", 0);
        repeat (3) @(negedge clk);

        push_fill(0, SIZE);
        issue(2, 0, 0, 0);
        repeat (10) @(negedge clk);
        #2 clr_n = 1'b0;
        wq.delete();
        fq.delete();
        fc_m = 0;
        #1;
        chk("midrst_wen", int'(buffer_wen), 0);
        chk("midrst_ready", int'(cmd_ready), 1);
        chk("midrst_first_char", int'(buffer_first_char), 0);
        chk("midrst_waddr", int'(buffer_waddr), 0);
        repeat (2) @(negedge clk);
        chk("inrst_wen", int'(buffer_wen), 0);
        release_reset();

        push_w(1, 8'h61);
        issue(0, 0, 1, 8'h61);
        wait_low("post_rst_put", 0);
        repeat (3) @(negedge clk);

        chk("write_queue_drained", wq.size(), 0);
        chk("fc_queue_drained", fq.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
